// File: rtl/csr_arb_pkg.sv
// rtl/csr_arb_pkg.sv - shared types and defaults for the two-master CSR bus arbiter
package csr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } arb_cmd_t;

endpackage

// File: rtl/csr_rr_arb2.sv
// rtl/csr_rr_arb2.sv - combinational 2-way round-robin pick with registered last grant
module csr_rr_arb2 (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic last_grant_q;

  assign valid_o = |req_i;

  // On a tie the master that lost last time wins; otherwise the sole requester.
  always_comb begin
    if (req_i == 2'b11) winner_o = ~last_grant_q;
    else                winner_o = req_i[1];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)     last_grant_q <= 1'b1;
    else if (accept_i) last_grant_q <= winner_o;
  end

endmodule

// File: rtl/csr_bus_arbiter.sv
// rtl/csr_bus_arbiter.sv - shares one CSR slave between two masters, one transaction in flight
module csr_bus_arbiter
  import csr_arb_pkg::*;
#(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [31:0] m0_wdata_bi,
  input  logic [3:0]  m0_be_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [31:0] m1_wdata_bi,
  input  logic [3:0]  m1_be_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [31:0] s_wdata_bo,
  output logic [3:0]  s_be_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,
  output logic        grant_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  arb_state_t  state_q, state_d;
  arb_cmd_t    cmd_q, cmd_d, sel_cmd;
  logic        owner_q, owner_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valid, winner, accept;
  logic        deliver, abort;
  logic [31:0] deliver_data;
  logic        m0_resp_q, m1_resp_q, timeout_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  assign accept = (state_q == IDLE) && valid;

  csr_rr_arb2 u_rr (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .req_i    ({m1_req_i, m0_req_i}),
    .accept_i (accept),
    .valid_o  (valid),
    .winner_o (winner)
  );

  // Ack is gated by reset so every output reads 0 while reset is held.
  assign m0_ack_o = arst_n_i & accept & ~winner;
  assign m1_ack_o = arst_n_i & accept &  winner;

  always_comb begin
    if (winner) sel_cmd = '{we: m1_we_i, addr: m1_addr_bi, be: m1_be_bi, wdata: m1_wdata_bi};
    else        sel_cmd = '{we: m0_we_i, addr: m0_addr_bi, be: m0_be_bi, wdata: m0_wdata_bi};
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    deliver      = 1'b0;
    deliver_data = '0;
    abort        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d   = sel_cmd;
          owner_d = winner;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (s_ack_i) begin
          state_d = cmd_q.we ? IDLE : WAIT_RESP;
          cnt_d   = cnt_q + 16'd1;
        end else if (cnt_q == CNT_LAST) begin
          abort        = 1'b1;
          deliver      = ~cmd_q.we;
          deliver_data = ERR_RDATA;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_RESP: begin
        // A response in the final counted cycle beats the timeout.
        if (s_resp_i) begin
          deliver      = 1'b1;
          deliver_data = s_rdata_bi;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abort        = 1'b1;
          deliver      = 1'b1;
          deliver_data = ERR_RDATA;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      m0_resp_q  <= 1'b0;
      m1_resp_q  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      m0_resp_q  <= deliver & ~owner_q;
      m1_resp_q  <= deliver &  owner_q;
      m0_rdata_q <= (deliver & ~owner_q) ? deliver_data : 32'd0;
      m1_rdata_q <= (deliver &  owner_q) ? deliver_data : 32'd0;
      timeout_q  <= abort;
    end
  end

  assign s_req_o     = (state_q == ISSUE);
  assign s_we_o      = s_req_o & cmd_q.we;
  assign s_addr_bo   = s_req_o ? cmd_q.addr  : 32'd0;
  assign s_wdata_bo  = s_req_o ? cmd_q.wdata : 32'd0;
  assign s_be_bo     = s_req_o ? cmd_q.be    : 4'd0;
  assign m0_resp_o   = m0_resp_q;
  assign m1_resp_o   = m1_resp_q;
  assign m0_rdata_bo = m0_rdata_q;
  assign m1_rdata_bo = m1_rdata_q;
  assign grant_o     = owner_q;
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// tb/tb_csr_bus_arbiter.sv - directed self-checking bench for csr_bus_arbiter
module tb_csr_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
  logic [3:0]  m0_be_bi, m1_be_bi;
  logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        s_ack_i, s_resp_i;
  logic [31:0] s_rdata_bi;
  logic        grant_o, busy_o, timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  csr_bus_arbiter #(.TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .m0_req_i    (m0_req_i),
    .m0_we_i     (m0_we_i),
    .m0_addr_bi  (m0_addr_bi),
    .m0_wdata_bi (m0_wdata_bi),
    .m0_be_bi    (m0_be_bi),
    .m0_ack_o    (m0_ack_o),
    .m0_resp_o   (m0_resp_o),
    .m0_rdata_bo (m0_rdata_bo),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_addr_bi  (m1_addr_bi),
    .m1_wdata_bi (m1_wdata_bi),
    .m1_be_bi    (m1_be_bi),
    .m1_ack_o    (m1_ack_o),
    .m1_resp_o   (m1_resp_o),
    .m1_rdata_bo (m1_rdata_bo),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_bo   (s_addr_bo),
    .s_wdata_bo  (s_wdata_bo),
    .s_be_bo     (s_be_bo),
    .s_ack_i     (s_ack_i),
    .s_resp_i    (s_resp_i),
    .s_rdata_bi  (s_rdata_bi),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    arst_n_i = 1'b0;
    m0_req_i = 0; m0_we_i = 0; m0_addr_bi = 0; m0_wdata_bi = 0; m0_be_bi = 0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_bi = 0; m1_wdata_bi = 0; m1_be_bi = 0;
    s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 0;
    #12;
    check("rst_s_req", s_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_resp", {m0_resp_o, m1_resp_o}, 0);
    check("rst_rdata", m0_rdata_bo | m1_rdata_bo, 0);
    arst_n_i = 1'b1;
    tick();

    // Single write from m0
    m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h80000000; m0_wdata_bi = 32'h000000A5; m0_be_bi = 4'hF;
    settle();
    check("wr_ack0", m0_ack_o, 1);
    check("wr_ack1", m1_ack_o, 0);
    check("wr_sreq_n", s_req_o, 0);
    tick();
    m0_req_i = 0; s_ack_i = 1;
    settle();
    check("wr_sreq_n1", s_req_o, 1);
    check("wr_swe", s_we_o, 1);
    check("wr_saddr", s_addr_bo, 32'h80000000);
    check("wr_swdata", s_wdata_bo, 32'h000000A5);
    check("wr_sbe", s_be_bo, 4'hF);
    tick();
    s_ack_i = 0;
    settle();
    check("wr_sreq_n2", s_req_o, 0);
    check("wr_swdata_idle", s_wdata_bo, 0);
    check("wr_busy_n2", busy_o, 0);
    check("wr_noresp", {m0_resp_o, m1_resp_o}, 0);

    // Read from m1 with slave response one cycle after ack
    m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h80000004; m1_be_bi = 4'hF;
    settle();
    check("rd_ack1", m1_ack_o, 1);
    check("rd_ack0", m0_ack_o, 0);
    tick();
    m1_req_i = 0; s_ack_i = 1;
    settle();
    check("rd_sreq", s_req_o, 1);
    check("rd_swe", s_we_o, 0);
    check("rd_saddr", s_addr_bo, 32'h80000004);
    tick();
    s_ack_i = 0; s_resp_i = 1; s_rdata_bi = 32'h12345678;
    settle();
    check("rd_sreq_drop", s_req_o, 0);
    check("rd_busy_wait", busy_o, 1);
    tick();
    s_resp_i = 0; s_rdata_bi = 0;
    settle();
    check("rd_resp1", m1_resp_o, 1);
    check("rd_rdata1", m1_rdata_bo, 32'h12345678);
    check("rd_resp0", m0_resp_o, 0);
    check("rd_rdata0", m0_rdata_bo, 0);
    check("rd_grant", grant_o, 1);
    check("rd_busy_n3", busy_o, 0);
    tick();
    check("rd_resp1_pulse", m1_resp_o, 0);
    check("rd_rdata1_clr", m1_rdata_bo, 0);

    // Tie: last grant was m1, so m0 wins first, then alternation
    m0_req_i = 1; m0_we_i = 1; m0_wdata_bi = 32'h11111111;
    m1_req_i = 1; m1_we_i = 1; m1_wdata_bi = 32'h22222222;
    s_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("tie_ack0_%0d", i), m0_ack_o, (i % 2 == 0) ? 1 : 0);
      check($sformatf("tie_ack1_%0d", i), m1_ack_o, (i % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("tie_grant_%0d", i), grant_o, (i % 2 == 1) ? 1 : 0);
      check($sformatf("tie_wdata_%0d", i), s_wdata_bo, (i % 2 == 0) ? 32'h11111111 : 32'h22222222);
      check($sformatf("tie_noack_%0d", i), {m0_ack_o, m1_ack_o}, 0);
      tick();
    end
    m0_req_i = 0; m1_req_i = 0; s_ack_i = 0;

    // Timeout: read acked but never answered
    m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h80000008;
    settle();
    check("to_ack0", m0_ack_o, 1);
    tick();
    m0_req_i = 0; s_ack_i = 1;
    tick();
    s_ack_i = 0;
    repeat (6) tick();
    check("to_not_yet", timeout_o, 0);
    check("to_busy", busy_o, 1);
    tick();
    check("to_pulse", timeout_o, 1);
    check("to_resp0", m0_resp_o, 1);
    check("to_rdata0", m0_rdata_bo, 32'hDEADBEEF);
    check("to_resp1", m1_resp_o, 0);
    check("to_busy_end", busy_o, 0);
    tick();
    check("to_pulse_end", timeout_o, 0);
    s_resp_i = 1; s_rdata_bi = 32'hBAD0BAD0;
    tick();
    s_resp_i = 0; s_rdata_bi = 0;
    settle();
    check("stray_resp", {m0_resp_o, m1_resp_o}, 0);
    check("stray_busy", busy_o, 0);
    check("stray_rdata", m0_rdata_bo, 0);

    // Collision: response lands in the final counted cycle
    m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h8000000C;
    settle();
    check("col_ack1", m1_ack_o, 1);
    tick();
    m1_req_i = 0; s_ack_i = 1;
    tick();
    s_ack_i = 0;
    repeat (6) tick();
    s_resp_i = 1; s_rdata_bi = 32'hCAFEF00D;
    tick();
    s_resp_i = 0; s_rdata_bi = 0;
    settle();
    check("col_resp1", m1_resp_o, 1);
    check("col_rdata1", m1_rdata_bo, 32'hCAFEF00D);
    check("col_no_to", timeout_o, 0);
    check("col_resp0", m0_resp_o, 0);
    tick();

    // Reset during WAIT_RESP
    m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h80000010;
    tick();
    m0_req_i = 0; s_ack_i = 1;
    tick();
    s_ack_i = 0;
    settle();
    check("mid_busy", busy_o, 1);
    arst_n_i = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_grant", grant_o, 0);
    check("mid_rst_sreq", s_req_o, 0);
    check("mid_rst_resp", {m0_resp_o, m1_resp_o, timeout_o}, 0);
    tick();
    arst_n_i = 1'b1;
    tick();
    check("post_rst_resp", {m0_resp_o, m1_resp_o, timeout_o}, 0);
    m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h80000020; m0_wdata_bi = 32'h5A5A5A5A;
    m1_req_i = 1; m1_we_i = 1;
    settle();
    check("post_rst_ack0", m0_ack_o, 1);
    check("post_rst_ack1", m1_ack_o, 0);
    tick();
    m0_req_i = 0; m1_req_i = 0; s_ack_i = 1;
    settle();
    check("post_rst_sreq", s_req_o, 1);
    check("post_rst_wdata", s_wdata_bo, 32'h5A5A5A5A);
    tick();
    s_ack_i = 0;
    settle();
    check("post_rst_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
